pattern_store: RTL and testbench

- Parametrised pattern memory: WIDTH-bit entries, DEPTH entries, all held in flops.
- Replaces one-hot field addressing with binary addresses.
- Read path is registered. Writes are bit-masked.
- Adds a sequencer step pointer with wrap flag, plus a counted serial shift chain with a completion pulse.
- Sits between the serial configuration interface and the pattern sequencer/field datapath.

---
 rtl/pattern_pkg.sv | 7 +
 rtl/pattern_store_ptr.sv | 40 ++++
 rtl/pattern_store.sv | 92 +++++++++
 tb/tb_pattern_store.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared defaults and encodings for the pattern store.
package pattern_pkg;
  localparam int PAT_WIDTH = 8;
  localparam int PAT_DEPTH = 32;
  localparam logic RD_SRC_ADDR = 1'b0;
  localparam logic RD_SRC_PTR  = 1'b1;
endpackage

// File: rtl/pattern_store_ptr.sv
// Sequencer step pointer: load with clamp, increment with wrap pulse.
module pattern_store_ptr
  import pattern_pkg::*;
#(
  parameter int DEPTH = PAT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] val,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic          wrap
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] clamped;

  assign clamped = (32'(val) >= DEPTH) ? LAST : val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        ptr <= clamped;
      end else if (inc) begin
        if (ptr == LAST) begin
          ptr  <= '0;
          wrap <= 1'b1;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pattern_store.sv
// Flop-based pattern memory: serial shift chain, masked writes,
// registered reads and a sequencer step pointer.
module pattern_store
  import pattern_pkg::*;
#(
  parameter int WIDTH = PAT_WIDTH,
  parameter int DEPTH = PAT_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(WIDTH * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             sin,
  output logic             sout,
  output logic             shift_done,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             rd_en,
  input  logic             rd_src,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             ptr_load,
  input  logic [AW-1:0]    ptr_val,
  input  logic             ptr_inc,
  output logic [AW-1:0]    ptr,
  output logic             ptr_wrap
);
  localparam int TOTAL = WIDTH * DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    rd_a;
  logic             wr_ok;
  logic             rd_ok;
  logic             last_shift;

  assign rd_a       = (rd_src == RD_SRC_PTR) ? ptr : rd_addr;
  assign wr_ok      = wr_en && !shift_en && (32'(wr_addr) < DEPTH);
  assign rd_ok      = 32'(rd_a) < DEPTH;
  assign last_shift = cnt == CW'(TOTAL - 1);
  assign sout       = mem[DEPTH-1][WIDTH-1];

  pattern_store_ptr #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ptr_load),
    .val  (ptr_val),
    .inc  (ptr_inc),
    .ptr  (ptr),
    .wrap (ptr_wrap)
  );

  // The whole array forms one chain, entry 0 bit 0 at the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < DEPTH; g++) mem[g] <= '0;
    end else if (shift_en) begin
      mem[0] <= {mem[0][WIDTH-2:0], sin};
      for (int g = 1; g < DEPTH; g++)
        mem[g] <= {mem[g][WIDTH-2:0], mem[g-1][WIDTH-1]};
    end else if (wr_ok) begin
      mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shift_done <= 1'b0;
    end else begin
      shift_done <= shift_en && last_shift;
      if (shift_en) cnt <= last_shift ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_ok ? mem[rd_a] : '0;
    end
  end
endmodule

// File: tb/tb_pattern_store.sv
// Bench for pattern_store: DEPTH=32 and DEPTH=20 builds share stimulus
// and are compared every cycle against a flat bit-vector reference model.
module tb_pattern_store;
  import pattern_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       shift_en, sin, wr_en, rd_en, rd_src, ptr_load, ptr_inc;
  logic [4:0] wr_addr, rd_addr, ptr_val;
  logic [7:0] wr_data, wr_mask;

  logic       sout [2];
  logic       done [2];
  logic       rv   [2];
  logic       wrap [2];
  logic [7:0] rdd  [2];
  logic [4:0] ptro [2];

  pattern_store #(.WIDTH(8), .DEPTH(32)) u0 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .sin(sin),
    .sout(sout[0]), .shift_done(done[0]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_src(rd_src), .rd_addr(rd_addr),
    .rd_data(rdd[0]), .rd_valid(rv[0]), .ptr_load(ptr_load),
    .ptr_val(ptr_val), .ptr_inc(ptr_inc), .ptr(ptro[0]),
    .ptr_wrap(wrap[0])
  );

  pattern_store #(.WIDTH(8), .DEPTH(20)) u1 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .sin(sin),
    .sout(sout[1]), .shift_done(done[1]), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_src(rd_src), .rd_addr(rd_addr),
    .rd_data(rdd[1]), .rd_valid(rv[1]), .ptr_load(ptr_load),
    .ptr_val(ptr_val), .ptr_inc(ptr_inc), .ptr(ptro[1]),
    .ptr_wrap(wrap[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: flat bit index = entry*8 + bit, so a shift is a plain
  // one-place move of the whole vector.
  bit [255:0] fl [2];
  int         pm [2];
  bit         wm [2];
  int         cm [2];
  bit         dm [2];
  bit [7:0]   rm [2];
  bit         vm [2];

  function automatic int dep(int k);
    return (k != 0) ? 20 : 32;
  endfunction

  function automatic bit [7:0] entry(int k, int a);
    bit [7:0] e;
    for (int b = 0; b < 8; b++) e[b] = fl[k][a*8+b];
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fl[k] = '0; pm[k] = 0; wm[k] = 0; cm[k] = 0;
      dm[k] = 0; rm[k] = '0; vm[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n, a, d;
      d = dep(k);
      n = d * 8;
      a = rd_src ? pm[k] : int'(rd_addr);
      if (rd_en) begin
        vm[k] = 1;
        rm[k] = (a < d) ? entry(k, a) : 8'h00;
      end else begin
        vm[k] = 0;
      end
      if (shift_en) begin
        for (int i = n - 1; i >= 1; i--) fl[k][i] = fl[k][i-1];
        fl[k][0] = sin;
        dm[k] = (cm[k] == n - 1);
        cm[k] = (cm[k] + 1) % n;
      end else begin
        dm[k] = 0;
        if (wr_en && int'(wr_addr) < d)
          for (int b = 0; b < 8; b++)
            if (wr_mask[b]) fl[k][int'(wr_addr)*8+b] = wr_data[b];
      end
      wm[k] = 0;
      if (ptr_load) begin
        pm[k] = (int'(ptr_val) >= d) ? d - 1 : int'(ptr_val);
      end else if (ptr_inc) begin
        if (pm[k] == d - 1) begin
          pm[k] = 0;
          wm[k] = 1;
        end else begin
          pm[k]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d rd_data", k), 32'(rdd[k]), 32'(rm[k]));
      chk($sformatf("d%0d rd_valid", k), 32'(rv[k]), 32'(vm[k]));
      chk($sformatf("d%0d ptr", k), 32'(ptro[k]), pm[k]);
      chk($sformatf("d%0d ptr_wrap", k), 32'(wrap[k]), 32'(wm[k]));
      chk($sformatf("d%0d shift_done", k), 32'(done[k]), 32'(dm[k]));
      chk($sformatf("d%0d sout", k), 32'(sout[k]),
          32'(fl[k][dep(k)*8-1]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    shift_en = 0; sin = 0; wr_en = 0; rd_en = 0; rd_src = RD_SRC_ADDR;
    ptr_load = 0; ptr_inc = 0; wr_addr = '0; rd_addr = '0;
    ptr_val = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d rst rd_data", k), 32'(rdd[k]), 0);
      chk($sformatf("d%0d rst rd_valid", k), 32'(rv[k]), 0);
      chk($sformatf("d%0d rst ptr", k), 32'(ptro[k]), 0);
      chk($sformatf("d%0d rst sout", k), 32'(sout[k]), 0);
      chk($sformatf("d%0d rst wrap", k), 32'(wrap[k]), 0);
      chk($sformatf("d%0d rst done", k), 32'(done[k]), 0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic rand_inputs();
    shift_en = ($urandom_range(7) == 0);
    sin      = 1'($urandom);
    wr_en    = 1'($urandom);
    wr_addr  = 5'($urandom);
    wr_data  = 8'($urandom);
    wr_mask  = 8'($urandom);
    rd_en    = 1'($urandom);
    rd_src   = 1'($urandom);
    rd_addr  = 5'($urandom);
    ptr_load = ($urandom_range(5) == 0);
    ptr_val  = 5'($urandom);
    ptr_inc  = 1'($urandom);
  endtask

  initial begin
    int c0, c1, at0, at1;
    bit [7:0] e;
    idle();
    rst_n = 0;
    #2;
    do_reset();

    // traffic then asynchronous reset mid-cycle
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      shift_en = 1'(i % 2);
      tick();
    end
    wr_en = 1; rd_en = 1; shift_en = 1; ptr_inc = 1;
    do_reset();
    idle(); rd_en = 1; rd_addr = 5;
    tick();
    chk("rst read addr5", 32'(rdd[0]), 32'h00);
    chk("rst read valid", 32'(rv[0]), 1);

    // masked writes
    idle(); wr_en = 1; wr_addr = 3; wr_data = 8'hFF; wr_mask = 8'hFF;
    tick();
    wr_data = 8'h00; wr_mask = 8'h0F;
    tick();
    idle(); rd_en = 1; rd_addr = 3;
    tick();
    chk("masked rd_data", 32'(rdd[0]), 32'hF0);
    chk("masked rd_valid", 32'(rv[0]), 1);
    wr_en = 1; wr_addr = 3; wr_data = 8'h11; wr_mask = 8'hFF;
    tick();
    chk("read before write", 32'(rdd[0]), 32'hF0);
    idle(); rd_en = 1; rd_addr = 3;
    tick();
    chk("write landed", 32'(rdd[0]), 32'h11);

    // serial fill; counters were cleared by the reset above
    c0 = 0; c1 = 0; at0 = 0; at1 = 0;
    idle();
    for (int i = 0; i < 256; i++) begin
      shift_en = 1; sin = (i % 3 == 0);
      tick();
      if (done[0]) begin c0++; at0 = i + 1; end
      if (done[1]) begin c1++; at1 = i + 1; end
    end
    idle();
    tick();
    if (done[0]) c0++;
    chk("d0 done count", c0, 1);
    chk("d0 done at", at0, 256);
    chk("d1 done count", c1, 1);
    chk("d1 done at", at1, 160);
    for (int a = 0; a < 32; a++) begin
      idle(); rd_en = 1; rd_addr = 5'(a);
      tick();
      for (int h = 0; h < 8; h++) e[h] = ((255 - (a * 8 + h)) % 3 == 0);
      chk($sformatf("fill entry %0d", a), 32'(rdd[0]), 32'(e));
    end
    chk("entry31 bit7 first bit", 32'(rdd[0][7]), 1);
    idle();
    for (int j = 0; j < 256; j++) begin
      chk($sformatf("sout stream %0d", j), 32'(sout[0]), 32'(j % 3 == 0));
      shift_en = 1; sin = 0;
      tick();
    end

    // shift beats write
    idle(); shift_en = 1; sin = 1;
    wr_en = 1; wr_addr = 0; wr_data = 8'hAA; wr_mask = 8'hFF;
    tick();
    idle(); rd_en = 1; rd_addr = 0;
    tick();
    chk("shift beats write", 32'(rdd[0]), 32'h01);

    // pointer
    idle(); ptr_load = 1; ptr_val = 30;
    tick();
    chk("ptr load 30", 32'(ptro[0]), 30);
    idle(); ptr_inc = 1;
    tick();
    chk("ptr 31", 32'(ptro[0]), 31);
    chk("wrap low 31", 32'(wrap[0]), 0);
    tick();
    chk("ptr wrap 0", 32'(ptro[0]), 0);
    chk("wrap pulse", 32'(wrap[0]), 1);
    tick();
    chk("ptr 1", 32'(ptro[0]), 1);
    chk("wrap low 1", 32'(wrap[0]), 0);
    idle(); ptr_load = 1; ptr_val = 25;
    tick();
    chk("d1 clamp", 32'(ptro[1]), 19);
    ptr_inc = 1; ptr_val = 7;
    tick();
    chk("load beats inc", 32'(ptro[0]), 7);
    idle(); ptr_load = 1; ptr_val = 19;
    tick();
    idle(); ptr_inc = 1; rd_en = 1; rd_src = RD_SRC_PTR;
    tick();
    chk("d1 wrap 19->0", 32'(ptro[1]), 0);
    chk("d1 wrap pulse", 32'(wrap[1]), 1);

    // out-of-range address on the DEPTH=20 build
    idle(); wr_en = 1; wr_addr = 25; wr_data = 8'hFF; wr_mask = 8'hFF;
    tick();
    idle(); rd_en = 1; rd_addr = 25;
    tick();
    chk("d1 oob rd_data", 32'(rdd[1]), 0);
    chk("d1 oob rd_valid", 32'(rv[1]), 1);
    chk("d0 addr25 written", 32'(rdd[0]), 32'hFF);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      if ($urandom_range(299) == 0) do_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
